ifetch_ctrl: RTL and testbench

- Instruction-fetch sequencer in front of the combinational 4K-word instruction memory (iaddr -> idata, same-cycle read).
- Owns the fetch PC, drives the memory address, and captures {pc, instr} pairs into a small prefetch FIFO.
- Hands pairs to decode over a valid/ready handshake.
- Handles control-flow redirects (flush plus restart), a halt request, and a retired-fetch counter.

---
 rtl/ifetch_ctrl_pkg.sv | 27 ++
 rtl/ifetch_ctrl_fifo.sv | 68 ++++++
 rtl/ifetch_ctrl.sv | 137 +++++++++++++
 tb/tb_ifetch_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_ctrl_pkg.sv
// Shared constants and types for the instruction-fetch block.
package ifetch_ctrl_pkg;

  localparam int          INSTR_W  = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  // BOOT burns one cycle after reset release so the memory address settles
  // before the first capture.
  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

  // One prefetch entry: the PC it was fetched from and the returned word.
  typedef struct packed {
    logic [INSTR_W-1:0] pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Instructions are word aligned; the low two address bits are dropped.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_ctrl_fifo.sv
// Small synchronous prefetch FIFO for {pc, instr} entries. Flush wins over
// push and pop; the caller never pushes when full without popping, and never
// pops when empty.
module ifetch_ctrl_fifo
  import ifetch_ctrl_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic                   i_flush,
  input  fetch_entry_t           i_data,
  output fetch_entry_t           o_data,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int PTR_W = $clog2(DEPTH);

  fetch_entry_t           r_mem [DEPTH];
  logic [PTR_W-1:0]       r_wr_ptr;
  logic [PTR_W-1:0]       r_rd_ptr;
  logic [PTR_W:0]         r_count;

  // Storage write; contents need no reset because the count gates the head.
  always_ff @(posedge i_clk) begin
    if (i_push && !i_flush) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (i_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Status flags and raw head entry.
  always_comb begin
    o_full  = (r_count == (PTR_W+1)'(DEPTH));
    o_empty = (r_count == '0);
    o_count = r_count;
    o_data  = r_mem[r_rd_ptr];
  end

endmodule

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, captures {pc, instr} from
// the combinational instruction memory into a prefetch FIFO, and presents the
// head to decode over valid/ready. Handles redirects, halt and a pop counter.
module ifetch_ctrl #(
  parameter logic [31:0] RESET_PC   = ifetch_ctrl_pkg::RESET_PC,
  parameter int          FIFO_DEPTH = 2,
  parameter int          CNT_W      = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  output logic [31:0]      o_iaddr,
  input  logic [31:0]      i_idata,
  input  logic             i_redirect_valid,
  input  logic [31:0]      i_redirect_pc,
  input  logic             i_halt_req,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [31:0]      o_out_pc,
  output logic [31:0]      o_out_instr,
  output logic             o_misalign,
  output logic [CNT_W-1:0] o_fetch_cnt
);

  import ifetch_ctrl_pkg::*;

  localparam int FIFO_CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e       r_state;
  fetch_state_e       w_state_nxt;
  logic [31:0]        r_fetch_pc;
  logic [CNT_W-1:0]   r_fetch_cnt;
  logic               r_misalign;

  logic               w_push;
  logic               w_pop;
  logic               w_out_valid;
  logic               w_has_head;
  logic               w_fifo_full;
  logic               w_fifo_empty;
  logic [FIFO_CW-1:0] w_fifo_count;
  fetch_entry_t       w_wr_entry;
  fetch_entry_t       w_head;

  // Handshake and push qualification. A redirect hides the head so decode
  // cannot consume an entry that is about to be flushed.
  always_comb begin
    w_has_head  = (w_fifo_count != '0);
    w_out_valid = !w_fifo_empty && !i_redirect_valid;
    w_pop       = w_out_valid && i_out_ready;
    w_push      = (r_state == ST_RUN) && !i_halt_req && !i_redirect_valid &&
                  (!w_fifo_full || w_pop);
    w_wr_entry  = '{pc: r_fetch_pc, instr: i_idata};
  end

  ifetch_ctrl_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (i_redirect_valid),
    .i_data  (w_wr_entry),
    .o_data  (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  // Fetch state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_BOOT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; a redirect never moves RUN into HALT in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_BOOT: w_state_nxt = ST_RUN;
      ST_RUN: begin
        if (i_halt_req && !i_redirect_valid) begin
          w_state_nxt = ST_HALT;
        end
      end
      ST_HALT: begin
        if (!i_halt_req) begin
          w_state_nxt = ST_RUN;
        end
      end
      default: w_state_nxt = ST_BOOT;
    endcase
  end

  // Fetch PC: reload on redirect, advance one word per captured entry.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fetch_pc <= RESET_PC;
    end else if (i_redirect_valid) begin
      r_fetch_pc <= align_pc(i_redirect_pc);
    end else if (w_push) begin
      r_fetch_pc <= r_fetch_pc + 32'd4;
    end
  end

  // Retired-fetch counter, wraps naturally.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fetch_cnt <= '0;
    end else if (w_pop) begin
      r_fetch_cnt <= r_fetch_cnt + CNT_W'(1);
    end
  end

  // One-cycle flag for a redirect target that was not word aligned.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_misalign <= 1'b0;
    end else begin
      r_misalign <= i_redirect_valid && (i_redirect_pc[1:0] != 2'b00);
    end
  end

  // Outputs; the head reads as zero while the FIFO is empty.
  always_comb begin
    o_iaddr     = r_fetch_pc;
    o_out_valid = w_out_valid;
    o_out_pc    = w_has_head ? w_head.pc    : 32'h0;
    o_out_instr = w_has_head ? w_head.instr : 32'h0;
    o_misalign  = r_misalign;
    o_fetch_cnt = r_fetch_cnt;
  end

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Bench for ifetch_ctrl: directed scenarios followed by random traffic, all
// checked against a queue-based reference model of the fetch pipeline.
module tb_ifetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] iaddr;
  logic [31:0] idata;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        halt_req = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        misalign;
  logic [31:0] fetch_cnt;

  logic [31:0] mem [4096];

  always #5 clk = ~clk;

  assign idata = mem[iaddr[13:2]];

  ifetch_ctrl #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (2),
    .CNT_W      (32)
  ) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .o_iaddr          (iaddr),
    .i_idata          (idata),
    .i_redirect_valid (redirect_valid),
    .i_redirect_pc    (redirect_pc),
    .i_halt_req       (halt_req),
    .o_out_valid      (out_valid),
    .i_out_ready      (out_ready),
    .o_out_pc         (out_pc),
    .o_out_instr      (out_instr),
    .o_misalign       (misalign),
    .o_fetch_cnt      (fetch_cnt)
  );

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: the prefetch buffer as a queue of {pc, instr}.
  logic [63:0] m_q [$];
  logic [31:0] m_pc;
  logic [31:0] m_cnt;
  bit          m_boot;
  bit          m_halted;
  bit          m_mis;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_pc     = 32'h0;
    m_cnt    = 32'h0;
    m_boot   = 1'b1;
    m_halted = 1'b0;
    m_mis    = 1'b0;
  endtask

  task automatic check_model();
    logic        ev;
    logic [31:0] epc;
    logic [31:0] ein;
    ev  = (m_q.size() != 0) && !redirect_valid;
    epc = (m_q.size() != 0) ? m_q[0][63:32] : 32'h0;
    ein = (m_q.size() != 0) ? m_q[0][31:0]  : 32'h0;
    chk("m_out_valid", {31'h0, out_valid}, {31'h0, ev});
    chk("m_out_pc",    out_pc,    epc);
    chk("m_out_instr", out_instr, ein);
    chk("m_iaddr",     iaddr,     m_pc);
    chk("m_misalign",  {31'h0, misalign}, {31'h0, m_mis});
    chk("m_fetch_cnt", fetch_cnt, m_cnt);
  endtask

  // One clock: apply inputs at the falling edge, check, then advance the model
  // across the rising edge. Redirect is treated as a one-cycle request.
  task automatic cycle(input bit rdy, input bit rv, input logic [31:0] rp, input bit hr);
    bit ev;
    bit pop;
    bit push;
    out_ready      = rdy;
    redirect_valid = rv;
    redirect_pc    = rp;
    halt_req       = hr;
    #1;
    check_model();
    ev   = (m_q.size() != 0) && !rv;
    pop  = ev && rdy;
    push = !m_boot && !m_halted && !hr && !rv && ((m_q.size() < 2) || pop);
    @(posedge clk);
    if (rv) begin
      m_q.delete();
      m_pc = {rp[31:2], 2'b00};
    end else begin
      if (pop) void'(m_q.pop_front());
      if (push) begin
        m_q.push_back({m_pc, mem[m_pc[13:2]]});
        m_pc = m_pc + 32'd4;
      end
    end
    if (pop) m_cnt = m_cnt + 32'd1;
    m_mis = rv && (rp[1:0] != 2'b00);
    if (m_boot)         m_boot   = 1'b0;
    else if (!m_halted) m_halted = hr && !rv;
    else                m_halted = hr;
    @(negedge clk);
    redirect_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] cnt_before;
    bit          rdy;
    bit          rv;
    bit          hr;
    logic [31:0] rp;

    for (int i = 0; i < 4096; i++) mem[i] = 32'h0000_0093 | (i << 20);

    // Reset state
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    #1;
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_misalign",  {31'h0, misalign},  32'h0);
    chk("rst_fetch_cnt", fetch_cnt, 32'h0);
    chk("rst_iaddr",     iaddr,     32'h0);
    chk("rst_out_pc",    out_pc,    32'h0);
    chk("rst_out_instr", out_instr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1. Reset latency and streaming
    cycle(1, 0, 32'h0, 0);
    chk("lat1_valid", {31'h0, out_valid}, 32'h0);
    cycle(1, 0, 32'h0, 0);
    chk("lat2_valid", {31'h0, out_valid}, 32'h1);
    chk("lat2_pc",    out_pc,    32'h0);
    chk("lat2_instr", out_instr, 32'h0000_0093);
    for (int i = 0; i < 10; i++) begin
      chk("stream_pc", out_pc, 32'(i) * 32'd4);
      cycle(1, 0, 32'h0, 0);
    end
    chk("stream_cnt", fetch_cnt, 32'd10);

    // 2. Backpressure
    cycle(0, 1, 32'h0, 0);
    for (int i = 0; i < 5; i++) cycle(0, 0, 32'h0, 0);
    chk("bp_iaddr", iaddr,  32'h8);
    chk("bp_head",  out_pc, 32'h0);
    chk("bp_valid", {31'h0, out_valid}, 32'h1);
    cycle(1, 0, 32'h0, 0);
    chk("bp_rel1", out_pc, 32'h4);
    cycle(1, 0, 32'h0, 0);
    chk("bp_rel2", out_pc, 32'h8);

    // 3. Redirect flushes queued entries
    cycle(0, 1, 32'h10, 0);
    cycle(0, 0, 32'h0, 0);
    cycle(0, 0, 32'h0, 0);
    chk("rd_head", out_pc, 32'h10);
    cnt_before = m_cnt;
    out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h100;
    #1;
    chk("rd_cycle_valid", {31'h0, out_valid}, 32'h0);
    cycle(1, 1, 32'h100, 0);
    chk("rd_no_pop",      fetch_cnt, cnt_before);
    chk("rd_after_valid", {31'h0, out_valid}, 32'h0);
    cycle(1, 0, 32'h0, 0);
    chk("rd_new_valid", {31'h0, out_valid}, 32'h1);
    chk("rd_new_pc",    out_pc, 32'h100);

    // 4. Misaligned redirect
    cycle(1, 1, 32'h203, 0);
    chk("mis_pulse", {31'h0, misalign}, 32'h1);
    chk("mis_iaddr", iaddr, 32'h200);
    cycle(1, 0, 32'h0, 0);
    chk("mis_clear", {31'h0, misalign}, 32'h0);
    chk("mis_pc",    out_pc, 32'h200);

    // 5. Halt drains the queue and holds the PC
    cycle(0, 1, 32'h300, 0);
    cycle(0, 0, 32'h0, 0);
    cycle(0, 0, 32'h0, 0);
    for (int i = 0; i < 4; i++) cycle(1, 0, 32'h0, 1);
    chk("halt_empty", {31'h0, out_valid}, 32'h0);
    chk("halt_pc",    iaddr, 32'h308);
    cycle(1, 0, 32'h0, 0);
    chk("unhalt_gap", {31'h0, out_valid}, 32'h0);
    cycle(1, 0, 32'h0, 0);
    chk("unhalt_pc",  out_pc, 32'h308);

    // 6. Address wrap and asynchronous reset
    cycle(1, 1, 32'hFFFF_FFFC, 0);
    cycle(1, 0, 32'h0, 0);
    chk("wrap_pc0", out_pc, 32'hFFFF_FFFC);
    cycle(1, 0, 32'h0, 0);
    chk("wrap_pc1", out_pc, 32'h0);
    cycle(1, 0, 32'h0, 0);
    chk("pre_rst_valid", {31'h0, out_valid}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'h0, out_valid}, 32'h0);
    chk("arst_cnt",   fetch_cnt, 32'h0);
    chk("arst_iaddr", iaddr,     32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic against the model
    hr = 1'b0;
    for (int i = 0; i < 600; i++) begin
      rdy = ($urandom_range(0, 3) != 0);
      rv  = ($urandom_range(0, 15) == 0);
      rp  = $urandom;
      if ($urandom_range(0, 5) == 0) rp = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      if ($urandom_range(0, 11) == 0) hr = !hr;
      cycle(rdy, rv, rp, hr);
    end
    cycle(1, 0, 32'h0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
